// File: rtl/cc_cond_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cc_cond_unit                                               |
// | Purpose  : Y86 condition-code register, jXX/cmovXX evaluator, M-stage |
// |            pipeline register and taken-jump counter.                  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module cc_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [2:0]       alu_cc,
    input  logic             excp_in,
    input  logic             m_stall,
    input  logic             m_bubble,
    output logic [2:0]       cc,
    output logic             e_cnd,
    output logic             cond_illegal,
    output logic             m_valid,
    output logic [3:0]       m_icode,
    output logic             m_cnd,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [3:0] c_ICODE_CMOV = 4'd2;
    localparam logic [3:0] c_ICODE_OPQ  = 4'd6;
    localparam logic [3:0] c_ICODE_JXX  = 4'd7;
    localparam logic [2:0] c_CC_RESET   = 3'b100;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_cc;
    logic             r_m_valid;
    logic [3:0]       r_m_icode;
    logic             r_m_cnd;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_set_cc;
    logic w_zf;
    logic w_x;
    logic w_is_cond_op;
    logic w_cond_raw;
    logic w_cnt_inc;

    assign w_set_cc     = e_valid & (e_icode == c_ICODE_OPQ) & ~excp_in;
    assign w_zf         = r_cc[2];
    assign w_x          = r_cc[1] ^ r_cc[0];
    assign w_is_cond_op = (e_icode == c_ICODE_CMOV) | (e_icode == c_ICODE_JXX);

    // Condition is taken from the stored flags only; selectors above 6 never fire.
    always_comb begin
        w_cond_raw = 1'b0;
        case (e_ifun)
            4'd0:    w_cond_raw = 1'b1;
            4'd1:    w_cond_raw = w_x | w_zf;
            4'd2:    w_cond_raw = w_x;
            4'd3:    w_cond_raw = w_zf;
            4'd4:    w_cond_raw = ~w_zf;
            4'd5:    w_cond_raw = ~w_x;
            4'd6:    w_cond_raw = ~w_x & ~w_zf;
            default: w_cond_raw = 1'b0;
        endcase
    end

    assign e_cnd        = e_valid & w_is_cond_op & w_cond_raw;
    assign cond_illegal = e_valid & w_is_cond_op & (e_ifun > 4'd6);

    assign w_cnt_inc = e_valid & (e_icode == c_ICODE_JXX) & (e_ifun != 4'd0)
                     & e_cnd & ~m_stall & ~m_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= c_CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= alu_cc;
        end
    end

    // Bubble takes priority over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_icode <= 4'd0;
            r_m_cnd   <= 1'b0;
        end else if (m_bubble) begin
            r_m_valid <= 1'b0;
            r_m_icode <= 4'd0;
            r_m_cnd   <= 1'b0;
        end else if (!m_stall) begin
            r_m_valid <= e_valid;
            r_m_icode <= e_icode;
            r_m_cnd   <= e_cnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_taken_cnt <= r_taken_cnt + c_CNT_ONE;
        end
    end

    assign cc        = r_cc;
    assign m_valid   = r_m_valid;
    assign m_icode   = r_m_icode;
    assign m_cnd     = r_m_cnd;
    assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire
